// File: rtl/a2d_spi_resp.sv
// -----------------------------------------------------------------------------
// a2d_spi_resp
//   SPI responder for the 16-bit A2D channel-read protocol. The command
//   received in frame N selects a channel through cmd[13:11]. Frame N+1 shifts
//   back {4'h0, sample} of that channel, MSB first. Samples come from a
//   flattened channel bus, so the block works as an ADC stand-in.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   SS_n       active-low slave select from the master
//   SCLK       serial clock from the master (much slower than clk)
//   MOSI       command bits; sampled on the synchronized SCLK rise
//   MISO       response bits; updated on the synchronized SCLK fall
//   chan_data  channel samples; channel k occupies bits [12k+11:12k]
//   cmd_rcvd   last complete 16-bit command
//   cmd_vld    one-clk pulse when a 16-bit frame completes
//   chan_sel   channel returned in the next frame
//   frame_err  sticky: some frame ended with a bit count other than 16
// -----------------------------------------------------------------------------
module a2d_spi_resp #(
    parameter int SYNC_STAGES = 2,   // synchronizer depth, minimum 2
    parameter int NUM_CH      = 8    // fixed by the 3-bit channel field
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   SS_n,
    input  logic                   SCLK,
    input  logic                   MOSI,
    output logic                   MISO,
    input  logic [12*NUM_CH-1:0]   chan_data,
    output logic [15:0]            cmd_rcvd,
    output logic                   cmd_vld,
    output logic [2:0]             chan_sel,
    output logic                   frame_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Synchronizers plus one history flop each.
    logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
    logic                   ss_hist, sclk_hist, mosi_hist;
    logic                   ss_s, sclk_s;
    logic                   ss_rise, sclk_rise, sclk_fall;

    // Marks how long the synchronizers have carried real input since reset.
    logic [SYNC_STAGES:0]   valid_sr;
    // Set once SS_n has been seen high through a settled synchronizer. This
    // keeps a frame that was cut by reset from being picked up half-way.
    logic                   armed;

    logic [15:0]            tx_shft, rx_shft;
    logic [4:0]             bit_cnt;
    logic [11:0]            sel_sample;

    logic                   start, rx_en, tx_en, commit, err_set;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the sync chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync   <= '1;
            ss_hist   <= 1'b1;
            sclk_sync <= '0;
            sclk_hist <= 1'b0;
            mosi_sync <= '0;
            mosi_hist <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
            ss_hist   <= ss_sync[SYNC_STAGES-1];
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            sclk_hist <= sclk_sync[SYNC_STAGES-1];
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            mosi_hist <= mosi_sync[SYNC_STAGES-1];
        end
    end

    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_rise   = ~ss_hist & ss_s;
    assign sclk_rise = ~sclk_hist & sclk_s;
    assign sclk_fall = sclk_hist & ~sclk_s;

    // Sample snapshot source for the frame about to start.
    assign sel_sample = chan_data[12*int'(chan_sel) +: 12];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        rx_en     = 1'b0;
        tx_en     = 1'b0;
        commit    = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                // Covers a fresh ss_fall and SS_n already low after a
                // back-to-back DONE.
                if (armed && !ss_s) begin
                    start     = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                rx_en = sclk_rise;
                // The first fall of a frame only brings SCLK down from idle.
                tx_en = sclk_fall && (bit_cnt != 5'd0);
                if (ss_rise) state_nxt = DONE;
            end
            DONE: begin
                if (bit_cnt == 5'd16) commit  = 1'b1;
                else                  err_set = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cmd_vld = commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_sr  <= '0;
            armed     <= 1'b0;
            tx_shft   <= '0;
            rx_shft   <= '0;
            bit_cnt   <= '0;
            cmd_rcvd  <= '0;
            chan_sel  <= '0;
            frame_err <= 1'b0;
        end else begin
            valid_sr <= {valid_sr[SYNC_STAGES-1:0], 1'b1};
            armed    <= armed | (valid_sr[SYNC_STAGES] & ss_s);

            if (start) begin
                tx_shft <= {4'h0, sel_sample};
                rx_shft <= '0;
                bit_cnt <= '0;
            end else begin
                if (rx_en) begin
                    // mosi_hist lines up with the history flop that sclk_rise uses.
                    rx_shft <= {rx_shft[14:0], mosi_hist};
                    if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
                end
                if (tx_en) tx_shft <= {tx_shft[14:0], 1'b0};
            end

            if (commit) begin
                cmd_rcvd <= rx_shft;
                chan_sel <= rx_shft[13:11];
            end
            if (err_set) frame_err <= 1'b1;
        end
    end

    assign MISO = ss_s ? 1'b0 : tx_shft[15];

endmodule

// File: tb/tb_a2d_spi_resp.sv
// -----------------------------------------------------------------------------
// tb_a2d_spi_resp
//   Directed bench for a2d_spi_resp. A bench-side SPI master drives 16-bit
//   frames (SCLK = clk/32, idling high), collects MISO just before each rise
//   and compares responses and status outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_a2d_spi_resp;

    logic        clk;
    logic        rst_n;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [95:0] chan_data;
    logic [15:0] cmd_rcvd;
    logic        cmd_vld;
    logic [2:0]  chan_sel;
    logic        frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int vld_cnt  = 0;

    a2d_spi_resp #(.SYNC_STAGES(2), .NUM_CH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .chan_data (chan_data),
        .cmd_rcvd  (cmd_rcvd),
        .cmd_vld   (cmd_vld),
        .chan_sel  (chan_sel),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Counts clocks with cmd_vld high, sampled away from the active edge.
    always @(negedge clk) if (cmd_vld) vld_cnt++;

    typedef struct {
        logic [15:0] cmd;
        bit          b2b;    // 1: one-clk SS_n-high gap before next frame
        logic [15:0] resp;   // expected MISO word in this frame
        logic [2:0]  sel;    // expected chan_sel after this frame
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic spi_frame(input logic [15:0] cmd, input int nbits, output logic [15:0] resp);
        resp = '0;
        SS_n = 1'b0;
        repeat (12) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b0;
            MOSI = cmd[15-i];
            repeat (16) @(negedge clk);
            resp = {resp[14:0], MISO};
            SCLK = 1'b1;
            repeat (16) @(negedge clk);
        end
        SS_n = 1'b1;
        MOSI = 1'b0;
    endtask

    task automatic full_frame_check(input string tag, input logic [15:0] cmd,
                                    input logic [15:0] exp_resp, input logic [2:0] exp_sel,
                                    input logic exp_err);
        logic [15:0] resp;
        int          v0;
        v0 = vld_cnt;
        spi_frame(cmd, 16, resp);
        repeat (8) @(negedge clk);
        check({tag, " resp"}, 32'(resp), 32'(exp_resp));
        check({tag, " cmd_rcvd"}, 32'(cmd_rcvd), 32'(cmd));
        check({tag, " chan_sel"}, 32'(chan_sel), 32'(exp_sel));
        check({tag, " vld pulses"}, 32'(vld_cnt - v0), 32'd1);
        check({tag, " frame_err"}, 32'(frame_err), 32'(exp_err));
        repeat (12) @(negedge clk);
    endtask

    initial begin
        logic [15:0] resp;
        int          v0;

        rst_n     = 1'b0;
        SS_n      = 1'b1;
        SCLK      = 1'b1;
        MOSI      = 1'b0;
        chan_data = '0;
        chan_data[0*12 +: 12] = 12'hABC;
        chan_data[4*12 +: 12] = 12'h123;
        chan_data[5*12 +: 12] = 12'hFED;

        vecs[0]  = '{16'h0000, 1'b0, 16'h0ABC, 3'd0};
        vecs[1]  = '{16'h2000, 1'b0, 16'h0ABC, 3'd4};
        vecs[2]  = '{16'h2800, 1'b0, 16'h0123, 3'd5};
        vecs[3]  = '{16'h0000, 1'b0, 16'h0FED, 3'd0};
        vecs[4]  = '{16'hC7FF, 1'b0, 16'h0ABC, 3'd0};   // don't-care bits kept
        vecs[5]  = '{16'h0000, 1'b1, 16'h0ABC, 3'd0};   // round robin starts
        vecs[6]  = '{16'h2000, 1'b1, 16'h0ABC, 3'd4};
        vecs[7]  = '{16'h2800, 1'b1, 16'h0123, 3'd5};
        vecs[8]  = '{16'h0000, 1'b1, 16'h0FED, 3'd0};
        vecs[9]  = '{16'h2000, 1'b1, 16'h0ABC, 3'd4};
        vecs[10] = '{16'h2800, 1'b1, 16'h0123, 3'd5};
        vecs[11] = '{16'h0000, 1'b1, 16'h0FED, 3'd0};
        vecs[12] = '{16'h2000, 1'b1, 16'h0ABC, 3'd4};
        vecs[13] = '{16'h2800, 1'b0, 16'h0123, 3'd5};

        repeat (4) @(negedge clk);
        check("reset cmd_rcvd", 32'(cmd_rcvd), 32'h0);
        check("reset chan_sel", 32'(chan_sel), 32'h0);
        check("reset cmd_vld", 32'(cmd_vld), 32'h0);
        check("reset frame_err", 32'(frame_err), 32'h0);
        check("reset MISO", 32'(MISO), 32'h0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Tests 1-3: table of single and back-to-back frames.
        v0 = vld_cnt;
        for (int i = 0; i < 14; i++) begin
            spi_frame(vecs[i].cmd, 16, resp);
            check($sformatf("vec%0d resp", i), 32'(resp), 32'(vecs[i].resp));
            if (vecs[i].b2b) begin
                @(negedge clk);
            end else begin
                repeat (8) @(negedge clk);
                check($sformatf("vec%0d cmd_rcvd", i), 32'(cmd_rcvd), 32'(vecs[i].cmd));
                check($sformatf("vec%0d chan_sel", i), 32'(chan_sel), 32'(vecs[i].sel));
                repeat (12) @(negedge clk);
            end
        end
        check("table vld pulses", 32'(vld_cnt - v0), 32'd14);
        check("table frame_err", 32'(frame_err), 32'h0);

        // Test 4: abort after 9 SCLKs.
        v0 = vld_cnt;
        spi_frame(16'h0000, 9, resp);
        repeat (8) @(negedge clk);
        check("abort frame_err", 32'(frame_err), 32'h1);
        check("abort vld pulses", 32'(vld_cnt - v0), 32'd0);
        check("abort chan_sel", 32'(chan_sel), 32'd5);
        check("abort cmd_rcvd", 32'(cmd_rcvd), 32'h2800);
        repeat (12) @(negedge clk);
        full_frame_check("after abort", 16'h0000, 16'h0FED, 3'd0, 1'b1);

        // Test 5: ch0 changes mid-frame; snapshot holds.
        chan_data[0*12 +: 12] = 12'h111;
        fork
            spi_frame(16'h0000, 16, resp);
            begin
                repeat (150) @(negedge clk);
                chan_data[0*12 +: 12] = 12'h222;
            end
        join
        repeat (20) @(negedge clk);
        check("midframe resp", 32'(resp), 32'h0111);
        full_frame_check("new ch0", 16'h0000, 16'h0222, 3'd0, 1'b1);

        // Test 6: reset during bit 7; remainder of that frame is ignored.
        v0 = vld_cnt;
        fork
            spi_frame(16'h3800, 16, resp);
            begin
                repeat (12 + 7*32 + 8) @(negedge clk);
                rst_n = 1'b0;
                repeat (3) @(negedge clk);
                check("midreset cmd_rcvd", 32'(cmd_rcvd), 32'h0);
                check("midreset chan_sel", 32'(chan_sel), 32'h0);
                check("midreset cmd_vld", 32'(cmd_vld), 32'h0);
                check("midreset frame_err", 32'(frame_err), 32'h0);
                check("midreset MISO", 32'(MISO), 32'h0);
                rst_n = 1'b1;
            end
        join
        repeat (20) @(negedge clk);
        check("cut frame vld pulses", 32'(vld_cnt - v0), 32'd0);
        check("cut frame frame_err", 32'(frame_err), 32'h0);
        full_frame_check("post reset", 16'h3800, 16'h0222, 3'd7, 1'b0);
        chan_data[7*12 +: 12] = 12'h5A5;
        full_frame_check("read ch7", 16'h0000, 16'h05A5, 3'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
